// File: rtl/repetition_scrubbed_register_pkg.sv
// Shared helpers for repetition-protected storage: vote threshold and tally sizing.
package repetition_scrubbed_register_pkg;

   // A bit votes 1 only when strictly more than half of the copies hold 1.
   function automatic int unsigned majority_threshold(input int unsigned copies);
      return copies / 2;
   endfunction

   // True when an exact half/half split is possible at a bit position.
   function automatic bit tie_possible(input int unsigned copies);
      return (copies % 2) == 0;
   endfunction

endpackage

// File: rtl/repetition_scrubbed_register_if.sv
// Register-bank side bundle for the repetition-scrubbed register.
interface repetition_scrubbed_register_if #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned REPETITION    = 3,
   parameter int unsigned COUNTER_WIDTH = 8
);
   logic                               write_enable;
   logic [DATA_WIDTH-1:0]              write_data;
   logic                               scrub_enable;
   logic                               inject_enable;
   logic [REPETITION*DATA_WIDTH-1:0]   inject_mask;
   logic                               error_clear;
   logic [DATA_WIDTH-1:0]              read_data;
   logic                               error;
   logic                               uncorrectable;
   logic                               error_sticky;
   logic [COUNTER_WIDTH-1:0]           error_count;

   modport master (
      output write_enable, write_data, scrub_enable, inject_enable, inject_mask, error_clear,
      input  read_data, error, uncorrectable, error_sticky, error_count
   );

   modport slave (
      input  write_enable, write_data, scrub_enable, inject_enable, inject_mask, error_clear,
      output read_data, error, uncorrectable, error_sticky, error_count
   );
endinterface

// File: rtl/repetition_scrubbed_register_voter.sv
// Combinational per-bit majority voter over packed copies; flags disagreement and exact ties.
module repetition_majority_voter
   import repetition_scrubbed_register_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned REPETITION = 3
) (
   input  logic [REPETITION*DATA_WIDTH-1:0] copies,
   output logic [DATA_WIDTH-1:0]            voted,
   output logic                             disagree,
   output logic                             tie
);
   localparam int unsigned THRESHOLD = majority_threshold(REPETITION);
   localparam bit          CAN_TIE   = tie_possible(REPETITION);

   int unsigned ones;

   // Tally ones per bit position, then vote and classify the disagreement.
   always_comb begin
      voted    = '0;
      disagree = 1'b0;
      tie      = 1'b0;
      ones     = 0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         ones = 0;
         for (int unsigned k = 0; k < REPETITION; k++) begin
            if (copies[k*DATA_WIDTH + i]) ones++;
         end
         voted[i] = (ones > THRESHOLD);
         if (ones != 0 && ones != REPETITION) disagree = 1'b1;
         if (CAN_TIE && (2 * ones == REPETITION)) tie = 1'b1;
      end
   end
endmodule

// File: rtl/repetition_scrubbed_register.sv
// Replicated storage register with majority read, optional scrub-on-error,
// fault injection, sticky error flag and saturating error counter.
module repetition_scrubbed_register
   import repetition_scrubbed_register_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH    = 8,
   parameter int unsigned           REPETITION    = 3,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0,
   parameter int unsigned           COUNTER_WIDTH = 8
) (
   input  logic                          clock,
   input  logic                          resetn,
   repetition_scrubbed_register_if.slave bus
);
   localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = 1;

   logic [REPETITION*DATA_WIDTH-1:0] copies;
   logic [REPETITION*DATA_WIDTH-1:0] copies_base;
   logic [REPETITION*DATA_WIDTH-1:0] copies_next;
   logic [DATA_WIDTH-1:0]            voted;
   logic                             disagree;
   logic                             tie;
   logic [COUNTER_WIDTH-1:0]         count_q;
   logic                             sticky_q;

   repetition_majority_voter #(
      .DATA_WIDTH (DATA_WIDTH),
      .REPETITION (REPETITION)
   ) u_voter (
      .copies   (copies),
      .voted    (voted),
      .disagree (disagree),
      .tie      (tie)
   );

   // Next copies: write beats scrub; injection is XORed on top of whichever base wins.
   always_comb begin
      copies_base = copies;
      if (bus.write_enable)
         copies_base = {REPETITION{bus.write_data}};
      else if (bus.scrub_enable && disagree)
         copies_base = {REPETITION{voted}};
      copies_next = bus.inject_enable ? (copies_base ^ bus.inject_mask) : copies_base;
   end

   // Copy storage.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) copies <= {REPETITION{RESET_VALUE}};
      else         copies <= copies_next;
   end

   // Saturating count of error cycles; clear wins over increment.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                       count_q <= '0;
      else if (bus.error_clear)          count_q <= '0;
      else if (disagree && count_q != '1) count_q <= count_q + COUNT_ONE;
   end

   // Sticky error flag; clear wins over set.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)               sticky_q <= 1'b0;
      else if (bus.error_clear)  sticky_q <= 1'b0;
      else if (disagree)         sticky_q <= 1'b1;
   end

   assign bus.read_data     = voted;
   assign bus.error         = disagree;
   assign bus.uncorrectable = tie;
   assign bus.error_sticky  = sticky_q;
   assign bus.error_count   = count_q;
endmodule

// File: tb/tb_repetition_scrubbed_register.sv
// Directed plus randomized bench for repetition_scrubbed_register (3- and 4-copy instances).
module tb_repetition_scrubbed_register;
   logic clock;
   logic resetn;
   int   checks   = 0;
   int   failures = 0;

   repetition_scrubbed_register_if #(.DATA_WIDTH(8), .REPETITION(3), .COUNTER_WIDTH(8)) bus3 ();
   repetition_scrubbed_register_if #(.DATA_WIDTH(8), .REPETITION(4), .COUNTER_WIDTH(8)) bus4 ();

   repetition_scrubbed_register #(
      .DATA_WIDTH(8), .REPETITION(3), .RESET_VALUE(8'h00), .COUNTER_WIDTH(8)
   ) dut3 (.clock(clock), .resetn(resetn), .bus(bus3.slave));

   repetition_scrubbed_register #(
      .DATA_WIDTH(8), .REPETITION(4), .RESET_VALUE(8'h00), .COUNTER_WIDTH(8)
   ) dut4 (.clock(clock), .resetn(resetn), .bus(bus4.slave));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference model for the 3-copy instance: an array of stored words.
   logic [7:0]  mc [3];
   int unsigned mcount;
   bit          msticky;

   function automatic logic [7:0] m_vote();
      logic [7:0] v;
      int n;
      v = '0;
      for (int b = 0; b < 8; b++) begin
         n = 0;
         for (int k = 0; k < 3; k++) n += int'(mc[k][b]);
         v[b] = (n >= 2);
      end
      return v;
   endfunction

   function automatic bit m_err();
      return !(mc[0] == mc[1] && mc[1] == mc[2]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) mc[k] = 8'h00;
      mcount  = 0;
      msticky = 0;
   endtask

   task automatic model_step();
      logic [7:0] base [3];
      logic [7:0] v;
      bit e;
      v = m_vote();
      e = m_err();
      for (int k = 0; k < 3; k++) begin
         if (bus3.write_enable)                base[k] = bus3.write_data;
         else if (bus3.scrub_enable && e)      base[k] = v;
         else                                  base[k] = mc[k];
      end
      for (int k = 0; k < 3; k++)
         mc[k] = bus3.inject_enable ? (base[k] ^ bus3.inject_mask[k*8 +: 8]) : base[k];
      if (bus3.error_clear) begin
         mcount  = 0;
         msticky = 0;
      end else if (e) begin
         if (mcount != 255) mcount++;
         msticky = 1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check3(input string tag);
      chk({tag, "_read"},   32'(bus3.read_data),     32'(m_vote()));
      chk({tag, "_err"},    32'(bus3.error),         32'(m_err()));
      chk({tag, "_unc"},    32'(bus3.uncorrectable), 32'h0);
      chk({tag, "_sticky"}, 32'(bus3.error_sticky),  32'(msticky));
      chk({tag, "_count"},  32'(bus3.error_count),   mcount);
   endtask

   // Advance one edge, update the model from the inputs seen at that edge, then settle.
   task automatic tick();
      @(posedge clock);
      if (resetn) model_step();
      #2;
   endtask

   task automatic idle_inputs();
      bus3.write_enable = 0; bus3.write_data = '0; bus3.scrub_enable = 0;
      bus3.inject_enable = 0; bus3.inject_mask = '0; bus3.error_clear = 0;
      bus4.write_enable = 0; bus4.write_data = '0; bus4.scrub_enable = 0;
      bus4.inject_enable = 0; bus4.inject_mask = '0; bus4.error_clear = 0;
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b0;
      model_reset();
      #3;
      check3("reset");
      chk("reset4_read", 32'(bus4.read_data), 32'h0);
      @(posedge clock); #2;
      resetn = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 10; i++) begin
         tick();
         check3("idle");
      end

      // Write 0xA5, flip copy 1 bit 0 without scrub, run to saturation.
      bus3.write_enable = 1; bus3.write_data = 8'hA5;
      tick();
      bus3.write_enable = 0;
      check3("write");
      bus3.inject_enable = 1; bus3.inject_mask = 24'h000100;
      tick();
      bus3.inject_enable = 0; bus3.inject_mask = '0;
      chk("inj_err", 32'(bus3.error), 32'h1);
      chk("inj_read", 32'(bus3.read_data), 32'hA5);
      for (int i = 0; i < 260; i++) begin
         tick();
         check3("noscrub");
      end
      chk("saturated", 32'(bus3.error_count), 32'd255);
      bus3.error_clear = 1;
      tick();
      bus3.error_clear = 0;
      chk("clr_count", 32'(bus3.error_count), 32'd0);
      chk("clr_sticky", 32'(bus3.error_sticky), 32'd0);
      tick();
      chk("resume_count", 32'(bus3.error_count), 32'd1);
      check3("resume");

      // Rewrite clean, then same injection with scrub enabled.
      bus3.write_enable = 1; bus3.write_data = 8'hA5; bus3.error_clear = 1;
      tick();
      bus3.write_enable = 0; bus3.error_clear = 0;
      bus3.scrub_enable = 1; bus3.inject_enable = 1; bus3.inject_mask = 24'h000100;
      tick();
      bus3.inject_enable = 0; bus3.inject_mask = '0;
      chk("scrub_err1", 32'(bus3.error), 32'h1);
      chk("scrub_read1", 32'(bus3.read_data), 32'hA5);
      tick();
      chk("scrub_err0", 32'(bus3.error), 32'h0);
      chk("scrub_copies", 32'(dut3.copies), 32'hA5A5A5);
      chk("scrub_count", 32'(bus3.error_count), 32'd1);
      chk("scrub_sticky", 32'(bus3.error_sticky), 32'd1);
      check3("scrub");
      bus3.scrub_enable = 0;

      // Write + pending scrub + inject on copy 2 bit 7.
      bus3.inject_enable = 1; bus3.inject_mask = 24'h000001;
      tick();
      bus3.write_enable = 1; bus3.write_data = 8'h3C; bus3.scrub_enable = 1;
      bus3.inject_mask = 24'h800000;
      tick();
      idle_inputs();
      chk("wsi_copies", 32'(dut3.copies), 32'hBC3C3C);
      chk("wsi_read", 32'(bus3.read_data), 32'h3C);
      chk("wsi_err", 32'(bus3.error), 32'h1);
      check3("wsi");

      // Build count=5 with error persisting, then reset mid-operation.
      bus3.error_clear = 1;
      tick();
      bus3.error_clear = 0;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_reset_count", 32'(bus3.error_count), 32'd5);
      resetn = 1'b0;
      model_reset();
      #1;
      chk("midrst_err", 32'(bus3.error), 32'h0);
      chk("midrst_count", 32'(bus3.error_count), 32'h0);
      check3("midrst");
      @(posedge clock); #2;
      resetn = 1'b1;
      tick();
      check3("postrst");

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bus3.write_enable  = ($urandom % 8) == 0;
         bus3.write_data    = 8'($urandom);
         bus3.scrub_enable  = ($urandom % 2) == 0;
         bus3.inject_enable = ($urandom % 5) == 0;
         bus3.inject_mask   = 24'($urandom) & 24'($urandom);
         bus3.error_clear   = ($urandom % 20) == 0;
         tick();
         check3("rand");
      end
      idle_inputs();

      // Four copies: tie at bit 3, then scrub to the tie-resolved value.
      bus4.write_enable = 1; bus4.write_data = 8'hFF;
      tick();
      bus4.write_enable = 0;
      bus4.inject_enable = 1; bus4.inject_mask = 32'h0000_0808;
      tick();
      bus4.inject_enable = 0; bus4.inject_mask = '0;
      chk("r4_unc", 32'(bus4.uncorrectable), 32'h1);
      chk("r4_read", 32'(bus4.read_data), 32'hF7);
      chk("r4_err", 32'(bus4.error), 32'h1);
      bus4.scrub_enable = 1;
      tick();
      bus4.scrub_enable = 0;
      chk("r4_copies", dut4.copies, 32'hF7F7F7F7);
      chk("r4_err0", 32'(bus4.error), 32'h0);
      chk("r4_unc0", 32'(bus4.uncorrectable), 32'h0);
      chk("r4_read2", 32'(bus4.read_data), 32'hF7);
      chk("r4_count", 32'(bus4.error_count), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/repetition_scrubbed_register.md
# repetition_scrubbed_register

Storage register holding REPETITION copies of a DATA_WIDTH word, read through a per-bit majority voter, with optional in-place scrubbing of disagreeing copies, a saturating error counter, a sticky error flag and a fault-injection port for verification. Used for configuration and state registers that must survive single-event upsets; it sits between a register-bank write path and the consuming logic.

## Interface
- DATA_WIDTH, 8: width of the protected word (≥1)
- REPETITION, 3: number of stored copies (≥2; even values enable tie detection)
- RESET_VALUE, 0: value loaded into every copy at reset
- COUNTER_WIDTH, 8: width of error_count (≥1)
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- write_enable  in  1  load write_data into all copies at next edge
- write_data  in  DATA_WIDTH  word to store
- scrub_enable  in  1  write voted value back to all copies when copies disagree
- inject_enable  in  1  apply inject_mask at next edge
- inject_mask  in  REPETITION*DATA_WIDTH  XOR mask on stored copies; copy k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- error_clear  in  1  clear error_count and error_sticky
- read_data  out  DATA_WIDTH  per-bit majority of stored copies
- error  out  1  at least one bit position has disagreeing copies
- uncorrectable  out  1  at least one bit position has an exact tie (even REPETITION only; constant 0 for odd)
- error_sticky  out  1  set by any cycle with error=1
- error_count  out  COUNTER_WIDTH  saturating count of cycles with error=1

## Operation
- Voter: per bit, read_data[i]=1 iff number of copies holding 1 > REPETITION/2 (integer division); a tie resolves to 0.
- error, uncorrectable, read_data: combinational from stored copies only (no input-to-output path).
- Next-state of copies, evaluated as base then mask:
  - base = write_data replicated if write_enable; else read_data replicated if scrub_enable && error; else current copies.
  - next = base XOR inject_mask if inject_enable, else base.
- write_enable has priority over scrub; injection applies on top of either, so write+inject stores a pre-corrupted word.
- Scrubbing with uncorrectable=1 still writes back the tie-resolved value (0 at tie bits); not suppressed.
- error_count: clear if error_clear; else +1 if error && count≠all-ones; else hold. Clear wins over simultaneous increment.
- error_sticky: 0 if error_clear; else set if error; else hold. Clear wins.

## Timing
- Reset (async assert, value held while resetn=0): all copies=RESET_VALUE, read_data=RESET_VALUE, error=0, uncorrectable=0, error_sticky=0, error_count=0. Deassertion is expected synchronous to clock externally.
- Write latency: read_data shows write_data one cycle after write_enable sampled.
- Injection: error rises the cycle after inject_enable sampled.
- Scrub: with scrub_enable held, a correctable error is visible for exactly one cycle; copies agree from the following cycle; error_count increments by 1 per error cycle.
- Without scrub, error persists and error_count increments every cycle until saturation at 2^COUNTER_WIDTH−1.
- Reset mid-operation: all state returns to reset values immediately, no partial scrub.

## Structure
- No shared package types needed; REPETITION/2 threshold is a local constant.
- One sub-module: repetition_majority_voter (combinational; inputs packed copies, outputs voted word, error, tie flag), reusable by other repetition-protected storage.
- Top level holds copy registers, next-state mux, counter and sticky flag.

## Test plan
- Reset then idle, DATA_WIDTH=8, REPETITION=3: read_data=0x00, error=0, error_count=0 for 10 cycles.
- Write 0xA5, then inject mask flipping copy 1 bit 0 with scrub_enable=0: read_data=0xA5, error=1 every cycle, error_count reaches 255 and holds; error_clear → count 0, sticky 0, then count resumes at 1.
- Same injection with scrub_enable=1: error=1 for one cycle, copies agree next cycle, error_count=1, error_sticky=1, read_data=0xA5 throughout.
- REPETITION=4, write 0xFF, flip bit 3 in copies 0 and 1: uncorrectable=1, read_data=0xF7; with scrub on, next cycle all copies 0xF7, error=0.
- Simultaneous write_enable (0x3C), scrub pending and inject flipping copy 2 bit 7: next cycle copies 0x3C,0x3C,0xBC, read_data=0x3C, error=1.
- Assert resetn=0 mid-error with count=5: outputs immediately reset values; after release error=0, count=0.
